axis_fifo: RTL
==============

AXIS_FIFO -- requirements
Module: axis_fifo

Interface
REQ-001 Parameter: DATA_W, 8, tdata width in bits.
REQ-002 Parameter: DEPTH, 8, number of stored beats; power of two, at least 2.
REQ-003 Parameter: PKT_MODE, 0, when 1 the output presents beats only once a whole packet (or a full FIFO) is stored.
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: s_tvalid  input  1  upstream beat valid.
REQ-007 Port: s_tready  output  1  FIFO can accept a beat.
REQ-008 Port: s_tdata  input  DATA_W  upstream beat data.
REQ-009 Port: s_tlast  input  1  upstream last beat of packet.
REQ-010 Port: m_tvalid  output  1  head beat presented downstream.
REQ-011 Port: m_tready  input  1  downstream accepts head beat.
REQ-012 Port: m_tdata  output  DATA_W  head beat data.
REQ-013 Port: m_tlast  output  1  head beat last flag.
REQ-014 Port: occupancy  output  $clog2(DEPTH)+1  stored beat count, range 0..DEPTH.

Function
REQ-015 Write shall occur on a rising edge with s_tvalid && s_tready; read shall occur on a rising edge with m_tvalid && m_tready.
REQ-016 Each entry shall store {tlast, tdata}; write and read pointers shall wrap modulo DEPTH.
REQ-017 s_tready shall equal (occupancy < DEPTH) and shall be 0 while rst is high.
REQ-018 m_tdata/m_tlast shall show the entry at the read pointer (first-word fall-through); the value is don't-care when m_tvalid is 0.
REQ-019 Latency: a beat written at edge N shall be visible with m_tvalid=1 after edge N when PKT_MODE=0.
REQ-020 occupancy shall increase by 1 on write only, decrease by 1 on read only, and stay unchanged on a simultaneous read and write.
REQ-021 PKT_MODE=0: m_tvalid shall be (occupancy != 0).
REQ-022 PKT_MODE=1: an internal pkt_cnt (0..DEPTH) shall increment on a write with s_tlast, decrement on a read with m_tlast, and stay unchanged when both occur in the same cycle.
REQ-023 PKT_MODE=1: m_tvalid shall be (occupancy != 0) && (pkt_cnt != 0 || occupancy == DEPTH), so an oversize packet cannot deadlock.
REQ-024 Once m_tvalid is asserted, m_tvalid, m_tdata and m_tlast shall stay stable until a read occurs.
REQ-025 When full, s_tvalid shall be ignored and no entry overwritten; a simultaneous read frees space only from the next cycle (s_tready derives from registered occupancy).
REQ-026 When empty, m_tready shall be ignored and occupancy shall not underflow.
REQ-027 Beats shall leave in write order with tdata and tlast unmodified; no beat shall be dropped or duplicated.

Reset
REQ-028 Asserting rst shall clear both pointers, occupancy and pkt_cnt to 0 immediately, discarding all stored beats, including mid-packet.
REQ-029 During reset s_tready=0, m_tvalid=0 and occupancy=0; after release s_tready=1 on the first edge.
REQ-030 Storage array contents shall not require reset.

Structure
REQ-031 A shared package axis_pkg shall hold the default DATA_W, the default DEPTH, and the beat typedef {logic last; logic [DATA_W-1:0] data}.
REQ-032 One sub-module, axis_fifo_mem, shall implement the storage: one synchronous write port and one asynchronous read port.
REQ-033 Pointer, count and valid logic shall live in axis_fifo itself, sized to sit between the existing AXIS master and slave without changes to either.

Verification
REQ-034 PKT_MODE=0, m_tready=1: write 0x11,0x22,0x33 (tlast on 0x33) back-to-back -> same beats appear one cycle later, in order, tlast only on 0x33.
REQ-035 m_tready=0: write 8 beats 0x00..0x07 -> occupancy=8, s_tready=0, 9th beat not stored; then m_tready=1 -> 0x00..0x07 read out, occupancy back to 0.
REQ-036 Occupancy 4, s_tvalid=m_tready=1 for 10 cycles -> occupancy stays 4, pointers wrap, order preserved.
REQ-037 PKT_MODE=1: write 0xA0,0xA1 without tlast -> m_tvalid=0; write 0xA2 with tlast -> m_tvalid=1 next cycle, 3 beats read, m_tvalid=0 after.
REQ-038 PKT_MODE=1: 8 beats without tlast -> m_tvalid=1 on full; all 8 drain.
REQ-039 Assert rst with occupancy 5 mid-packet -> occupancy=0, m_tvalid=0, s_tready=0 at once; after release the next beat written is the first one read.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI-Stream FIFO defaults and the stored beat layout.
package axis_pkg;

   localparam int unsigned AXIS_DATA_W = 8;
   localparam int unsigned AXIS_DEPTH  = 8;

   typedef struct packed {
      logic                   last;
      logic [AXIS_DATA_W-1:0] data;
   } beat_t;

endpackage : axis_pkg

// File: rtl/axis_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module axis_fifo_mem
   import axis_pkg::*;
#(
   parameter int unsigned WIDTH = AXIS_DATA_W + 1,
   parameter int unsigned DEPTH = AXIS_DEPTH
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule : axis_fifo_mem

// File: rtl/axis_fifo.sv
// First-word fall-through AXI-Stream FIFO with optional packet-gated output.
module axis_fifo
   import axis_pkg::*;
#(
   parameter int unsigned DATA_W   = AXIS_DATA_W,
   parameter int unsigned DEPTH    = AXIS_DEPTH,
   parameter bit          PKT_MODE = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   input  logic [DATA_W-1:0]      s_tdata,
   input  logic                   s_tlast,
   output logic                   m_tvalid,
   input  logic                   m_tready,
   output logic [DATA_W-1:0]      m_tdata,
   output logic                   m_tlast,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] occ, pkt_cnt;
   logic          full, wr, rd, wr_last, rd_last;
   entry_t        wr_entry, rd_entry;

   assign full = (occ == CW'(DEPTH));

   // In packet mode a full FIFO also releases the head so an oversize packet drains.
   always_comb begin
      s_tready = !rst && !full;
      m_tvalid = (occ != '0) && (!PKT_MODE || (pkt_cnt != '0) || full);
   end

   assign wr      = s_tvalid && s_tready;
   assign rd      = m_tvalid && m_tready;
   assign wr_last = wr && s_tlast;
   assign rd_last = rd && m_tlast;

   assign wr_entry  = '{last: s_tlast, data: s_tdata};
   assign m_tdata   = rd_entry.data;
   assign m_tlast   = rd_entry.last;
   assign occupancy = occ;

   axis_fifo_mem #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr),
      .wr_addr (wr_ptr),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr),
      .rd_data (rd_entry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         occ     <= '0;
         pkt_cnt <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + AW'(1);
         if (rd) rd_ptr <= rd_ptr + AW'(1);
         case ({wr, rd})
            2'b10:   occ <= occ + CW'(1);
            2'b01:   occ <= occ - CW'(1);
            default: ;
         endcase
         case ({wr_last, rd_last})
            2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
            2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
            default: ;
         endcase
      end
   end

endmodule : axis_fifo
